// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter, next-PC select and run/halt control; optional PC_ALIGN_CHECK_EN
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_WORDS  = 64,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr26,
    input  logic [31:0] jr_target,
    input  logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        pc_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;

    logic [31:0] br_offset;
    logic [31:0] target;
    logic [31:0] target_ld;
    logic        misalign;
    logic        out_of_range;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_err      = err_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);

    // Candidate next PC from the selected source, then alignment and range screening
    always_comb begin
        br_offset = {{14{imm16[15]}}, imm16, 2'b00};
        target    = pc_plus4;
        case (pc_src)
            2'b00: target = pc_plus4;
            2'b01: target = branch_taken ? (pc_plus4 + br_offset) : pc_plus4;
            2'b10: target = {pc_plus4[31:28], jaddr26, 2'b00};
            2'b11: target = jr_target;
            default: target = pc_plus4;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        misalign  = (target[1:0] != 2'b00);
        target_ld = target;
`else
        misalign  = 1'b0;
        target_ld = target & 32'hFFFF_FFFC;
`endif
        out_of_range = (target_ld >= PC_LIMIT);
    end

    // Next-state logic: BOOT lasts one cycle, RUN loads the PC or halts, HALT is terminal
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (opcode == HALT_OPCODE) begin
                        state_d = ST_HALT;
                    end else if (misalign || out_of_range) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = target_ld;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State, PC and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule
